// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding, UART register addresses and sizing helpers for mem_arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRAM,
    ST_U_WR,
    ST_U_RD,
    ST_U_STAT
  } state_e;

  localparam int UART_DATA_ADDR = 'hBF00;
  localparam int UART_STAT_ADDR = 'hBF01;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_arbiter_sync2.sv
// Two-flop synchronizer for asynchronous UART status lines; output resets to 0.
module mem_arbiter_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the RAM1 sram controller between IF and MEM ports; maps UART data/status into MEM space.
// UART decode, strobes and status synchronizers exist only when MEM_ARB_UART_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int SRAM_CYC   = 2,
  parameter int UART_PULSE = 2,
  parameter int UART_DATA  = UART_DATA_ADDR,
  parameter int UART_STAT  = UART_STAT_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ack_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ram_ctl_en_o,
  output logic              ram_ctl_op_o,
  output logic [ADDR_W-1:0] ram_ctl_addr_o,
  output logic [DATA_W-1:0] ram_ctl_wdata_o,
  input  logic [DATA_W-1:0] ram_ctl_rdata_i,
  output logic [DATA_W-1:0] uart_data_o,
  output logic              uart_oe_o,
  input  logic [DATA_W-1:0] uart_data_i,
  input  logic              tsre_i,
  input  logic              tbre_i,
  input  logic              data_ready_i,
  output logic              rdn_o,
  output logic              wrn_o
);

  localparam int CNT_W = $clog2(max2(SRAM_CYC, UART_PULSE)) + 1;

  state_e            state_q, state_d, mem_tgt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_own_q, mem_own_d, we_q, we_d, fair_q, fair_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              en_q, en_d, op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, uart_dat_q, uart_dat_d;
  logic              uart_oe_q, uart_oe_d, rdn_q, rdn_d, wrn_q, wrn_d;
  logic              dr_s, tsre_s, tbre_s;
  logic              if_v, mem_v;

  // A requester still sees its own ack this cycle, so its held req is not a new request.
  assign if_v  = if_req_i & ~if_ack_q;
  assign mem_v = mem_req_i & ~mem_ack_q;

  always_comb begin
    mem_tgt = ST_SRAM;
`ifdef MEM_ARB_UART_EN
    if (mem_addr_i == ADDR_W'(UART_DATA)) begin
      mem_tgt = mem_we_i ? ST_U_WR : ST_U_RD;
    end else if (mem_addr_i == ADDR_W'(UART_STAT)) begin
      mem_tgt = ST_U_STAT;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_own_d   = mem_own_q;
    we_d        = we_q;
    fair_d      = fair_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    en_d        = en_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    uart_dat_d  = uart_dat_q;
    uart_oe_d   = uart_oe_q;
    rdn_d       = rdn_q;
    wrn_d       = wrn_q;
    case (state_q)
      ST_IDLE: begin
        if (if_v && (!mem_v || fair_q)) begin
          state_d   = ST_SRAM;
          mem_own_d = 1'b0;
          fair_d    = 1'b0;
          en_d      = 1'b1;
          op_d      = 1'b0;
          addr_d    = if_addr_i;
          wdata_d   = '0;
          cnt_d     = CNT_W'(SRAM_CYC - 1);
        end else if (mem_v) begin
          state_d   = mem_tgt;
          mem_own_d = 1'b1;
          we_d      = mem_we_i;
          fair_d    = if_v;
          case (mem_tgt)
            ST_SRAM: begin
              en_d    = 1'b1;
              op_d    = mem_we_i;
              addr_d  = mem_addr_i;
              wdata_d = mem_wdata_i;
              cnt_d   = CNT_W'(SRAM_CYC - 1);
            end
            ST_U_WR: begin
              uart_oe_d  = 1'b1;
              uart_dat_d = mem_wdata_i;
              cnt_d      = CNT_W'(UART_PULSE);
            end
            ST_U_RD: begin
              rdn_d = 1'b0;
              cnt_d = CNT_W'(UART_PULSE - 1);
            end
            default: ;
          endcase
        end
      end
      ST_SRAM: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          if (mem_own_q) begin
            mem_ack_d = 1'b1;
            if (!op_q) mem_rdata_d = ram_ctl_rdata_i;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_ctl_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_U_WR: begin
        // First cycle drives data with wrn high; the counter then times the low pulse.
        if (cnt_q != '0) begin
          wrn_d = 1'b0;
          cnt_d = cnt_q - 1'b1;
        end else begin
          wrn_d     = 1'b1;
          uart_oe_d = 1'b0;
          mem_ack_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_U_RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdn_d       = 1'b1;
          mem_rdata_d = {{(DATA_W-8){1'b0}}, uart_data_i[7:0]};
          mem_ack_d   = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_U_STAT: begin
        if (!we_q) mem_rdata_d = {{(DATA_W-2){1'b0}}, dr_s, tsre_s & tbre_s};
        mem_ack_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_own_q   <= 1'b0;
      we_q        <= 1'b0;
      fair_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      en_q        <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      uart_dat_q  <= '0;
      uart_oe_q   <= 1'b0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_own_q   <= mem_own_d;
      we_q        <= we_d;
      fair_q      <= fair_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      en_q        <= en_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      uart_dat_q  <= uart_dat_d;
      uart_oe_q   <= uart_oe_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
    end
  end

  assign if_ack_o        = if_ack_q;
  assign if_rdata_o      = if_rdata_q;
  assign mem_ack_o       = mem_ack_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign ram_ctl_en_o    = en_q;
  assign ram_ctl_op_o    = op_q;
  assign ram_ctl_addr_o  = addr_q;
  assign ram_ctl_wdata_o = wdata_q;

`ifdef MEM_ARB_UART_EN
  mem_arbiter_sync2 u_sync_dr   (.clk(clk), .rst_n(rst_n), .d_i(data_ready_i), .q_o(dr_s));
  mem_arbiter_sync2 u_sync_tsre (.clk(clk), .rst_n(rst_n), .d_i(tsre_i),       .q_o(tsre_s));
  mem_arbiter_sync2 u_sync_tbre (.clk(clk), .rst_n(rst_n), .d_i(tbre_i),       .q_o(tbre_s));

  assign uart_data_o = uart_dat_q;
  assign uart_oe_o   = uart_oe_q;
  assign rdn_o       = rdn_q;
  assign wrn_o       = wrn_q;

  logic unused_uart_hi;
  assign unused_uart_hi = &{1'b0, uart_data_i[DATA_W-1:8]};
`else
  assign dr_s        = 1'b0;
  assign tsre_s      = 1'b0;
  assign tbre_s      = 1'b0;
  assign uart_data_o = '0;
  assign uart_oe_o   = 1'b0;
  assign rdn_o       = 1'b1;
  assign wrn_o       = 1'b1;

  logic unused_uart;
  assign unused_uart = &{1'b0, rdn_q, wrn_q, uart_oe_q, uart_dat_q, uart_data_i,
                         tsre_i, tbre_i, data_ready_i, UART_DATA[0], UART_STAT[0]};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int SC = 2;
  localparam int UP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [AW-1:0] if_addr = '0, mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0, u_din = '0;
  logic          tsre = 1'b0, tbre = 1'b0, dready = 1'b0;
  logic          if_ack, mem_ack, ram_en, ram_op, u_oe, rdn, wrn;
  logic [DW-1:0] if_rdata, mem_rdata, ram_wdata, ram_rdata, u_dout;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .SRAM_CYC(SC), .UART_PULSE(UP)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata),
    .ram_ctl_en_o(ram_en), .ram_ctl_op_o(ram_op), .ram_ctl_addr_o(ram_addr),
    .ram_ctl_wdata_o(ram_wdata), .ram_ctl_rdata_i(ram_rdata),
    .uart_data_o(u_dout), .uart_oe_o(u_oe), .uart_data_i(u_din),
    .tsre_i(tsre), .tbre_i(tbre), .data_ready_i(dready), .rdn_o(rdn), .wrn_o(wrn)
  );

  // SRAM device (1K words, address folded) and the expected contents of each word.
  logic [DW-1:0] sram    [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  assign ram_rdata = sram[ram_addr[9:0]];
  always @(posedge clk) if (ram_en && ram_op) sram[ram_addr[9:0]] <= ram_wdata;

  int n_chk = 0, n_pass = 0;
  int seq_log[$];
  int en_cnt = 0, wrn_lo = 0, rdn_lo = 0, oe_cnt = 0, oe_off_wrn = 0, ack_cnt = 0;
  logic [7:0]    wr_byte = '0;
  logic [AW-1:0] en_addr = '0;

  always @(negedge clk) begin
    if (ram_en) begin en_cnt++; en_addr = ram_addr; end
    if (!rdn) rdn_lo++;
    if (u_oe) oe_cnt++;
    if (mem_ack) ack_cnt++;
    if (!wrn) begin
      wrn_lo++;
      if (u_oe) wr_byte = u_dout[7:0]; else oe_off_wrn++;
    end
  end

  task automatic sync_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_if(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    if_addr = a; if_req = 1'b1; lat = 0; d = '0;
    while (lat < 60) begin
      @(posedge clk); lat++; #1;
      if (if_ack) begin d = if_rdata; seq_log.push_back(1); break; end
    end
    if_req = 1'b0;
  endtask

  task automatic do_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w,
                        output logic [DW-1:0] d, output int lat);
    mem_we = we; mem_addr = a; mem_wdata = w; mem_req = 1'b1; lat = 0; d = '0;
    while (lat < 60) begin
      @(posedge clk); lat++; #1;
      if (mem_ack) begin d = mem_rdata; seq_log.push_back(0); break; end
    end
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; if_addr = 18'h10;
    repeat (2) @(posedge clk); #1;
    n_chk++;
    if ({if_ack, mem_ack, ram_en, ram_op, u_oe, rdn, wrn} !== 7'b0000011)
      $display("FAIL reset_ctl: got %b expected 0000011", {if_ack, mem_ack, ram_en, ram_op, u_oe, rdn, wrn});
    else n_pass++;
    n_chk++;
    if ({if_rdata, mem_rdata, ram_addr, ram_wdata} !== '0)
      $display("FAIL reset_data: got %h expected 0", {if_rdata, mem_rdata, ram_addr, ram_wdata});
    else n_pass++;
    if_req = 1'b0;
    rst_n = 1'b1;
    sync_cyc();
  endtask

  task automatic test_if_read();
    logic [DW-1:0] d; int lat, e0;
    sram[16] = 16'h1234; ref_mem[16] = 16'h1234;
    e0 = en_cnt;
    do_if(18'h00010, d, lat);
    n_chk++; if (lat != SC + 1) $display("FAIL if_lat: got %0d expected %0d", lat, SC + 1); else n_pass++;
    n_chk++; if (d !== 16'h1234) $display("FAIL if_rdata: got %h expected 1234", d); else n_pass++;
    n_chk++; if (ram_en !== 1'b0) $display("FAIL if_en_drop: got %b expected 0", ram_en); else n_pass++;
    sync_cyc();
    n_chk++; if (en_cnt - e0 != SC) $display("FAIL if_en_cycles: got %0d expected %0d", en_cnt - e0, SC); else n_pass++;
  endtask

  task automatic test_simul();
    logic [DW-1:0] md, id, rd; int mlat, ilat, lat; logic op1, en1; logic [AW-1:0] a1;
    seq_log.delete();
    fork
      do_mem(1'b1, 18'h00040, 16'hBEEF, md, mlat);
      do_if(18'h00010, id, ilat);
      begin @(posedge clk); #2; op1 = ram_op; en1 = ram_en; a1 = ram_addr; end
    join
    ref_mem[64] = 16'hBEEF;
    n_chk++; if (seq_log.size() != 2 || seq_log[0] != 0 || seq_log[1] != 1)
      $display("FAIL simul_order: got size %0d expected MEM then IF", seq_log.size()); else n_pass++;
    n_chk++; if ({en1, op1, a1} !== {2'b11, 18'h00040})
      $display("FAIL simul_grant: got en=%b op=%b addr=%h expected 1 1 00040", en1, op1, a1); else n_pass++;
    n_chk++; if (mlat != SC + 1 || ilat != 2 * (SC + 1))
      $display("FAIL simul_lat: got %0d/%0d expected %0d/%0d", mlat, ilat, SC + 1, 2 * (SC + 1)); else n_pass++;
    n_chk++; if (id !== ref_mem[16]) $display("FAIL simul_if_data: got %h expected %h", id, ref_mem[16]); else n_pass++;
    sync_cyc();
    do_mem(1'b0, 18'h00040, 16'h0, rd, lat);
    n_chk++; if (rd !== 16'hBEEF) $display("FAIL simul_readback: got %h expected beef", rd); else n_pass++;
    sync_cyc();
  endtask

  task automatic test_fair();
    int exp_seq[5] = '{0, 1, 0, 1, 0};
    seq_log.delete();
    fork
      begin
        logic [DW-1:0] d; int lat; logic [AW-1:0] a;
        for (int k = 0; k < 3; k++) begin
          a = 18'($urandom_range(0, 1023));
          do_mem(1'b0, a, 16'h0, d, lat);
          n_chk++; if (d !== ref_mem[a[9:0]]) $display("FAIL fair_mem_data: got %h expected %h", d, ref_mem[a[9:0]]); else n_pass++;
        end
      end
      begin
        logic [DW-1:0] d; int lat; logic [AW-1:0] a;
        for (int k = 0; k < 2; k++) begin
          a = 18'($urandom_range(0, 1023));
          do_if(a, d, lat);
          n_chk++; if (d !== ref_mem[a[9:0]]) $display("FAIL fair_if_data: got %h expected %h", d, ref_mem[a[9:0]]); else n_pass++;
        end
      end
    join
    n_chk++; if (seq_log.size() != 5) $display("FAIL fair_count: got %0d expected 5", seq_log.size()); else n_pass++;
    for (int k = 0; k < 5 && k < seq_log.size(); k++) begin
      n_chk++; if (seq_log[k] != exp_seq[k]) $display("FAIL fair_order[%0d]: got %0d expected %0d", k, seq_log[k], exp_seq[k]); else n_pass++;
    end
    sync_cyc();
  endtask

  task automatic test_random();
    logic [DW-1:0] d, w; int lat; logic [AW-1:0] a;
    for (int i = 0; i < 30; i++) begin
      a = 18'($urandom_range(0, 1023)); w = 16'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          do_if(a, d, lat);
          n_chk++; if (d !== ref_mem[a[9:0]] || lat != SC + 1)
            $display("FAIL rand_if: got %h lat %0d expected %h lat %0d", d, lat, ref_mem[a[9:0]], SC + 1); else n_pass++;
        end
        1: begin
          do_mem(1'b0, a, 16'h0, d, lat);
          n_chk++; if (d !== ref_mem[a[9:0]] || lat != SC + 1)
            $display("FAIL rand_mem_rd: got %h lat %0d expected %h lat %0d", d, lat, ref_mem[a[9:0]], SC + 1); else n_pass++;
        end
        default: begin
          do_mem(1'b1, a, w, d, lat);
          ref_mem[a[9:0]] = w;
          n_chk++; if (lat != SC + 1) $display("FAIL rand_mem_wr: got lat %0d expected %0d", lat, SC + 1); else n_pass++;
        end
      endcase
      repeat ($urandom_range(1, 3)) sync_cyc();
    end
  endtask

  task automatic test_if_uart_addr();
    logic [DW-1:0] d; int lat, e0;
    e0 = en_cnt;
    do_if(18'h0BF00, d, lat);
    sync_cyc();
    n_chk++; if (d !== ref_mem[10'h300] || en_cnt - e0 != SC)
      $display("FAIL if_uart_addr: got %h en %0d expected %h en %0d", d, en_cnt - e0, ref_mem[10'h300], SC); else n_pass++;
  endtask

`ifdef MEM_ARB_UART_EN
  task automatic test_uart_write();
    logic [DW-1:0] d; int lat, w0, r0, e0, o0, f0;
    w0 = wrn_lo; r0 = rdn_lo; e0 = en_cnt; o0 = oe_cnt; f0 = oe_off_wrn;
    do_mem(1'b1, 18'h0BF00, 16'h0041, d, lat);
    repeat (2) sync_cyc();
    n_chk++; if (lat != UP + 2) $display("FAIL uwr_lat: got %0d expected %0d", lat, UP + 2); else n_pass++;
    n_chk++; if (wrn_lo - w0 != UP) $display("FAIL uwr_wrn_low: got %0d expected %0d", wrn_lo - w0, UP); else n_pass++;
    n_chk++; if (wr_byte !== 8'h41 || oe_off_wrn != f0) $display("FAIL uwr_data: got %h expected 41 with oe", wr_byte); else n_pass++;
    n_chk++; if (oe_cnt - o0 < UP) $display("FAIL uwr_oe: got %0d expected >=%0d", oe_cnt - o0, UP); else n_pass++;
    n_chk++; if (rdn_lo != r0 || en_cnt != e0) $display("FAIL uwr_side: got rdn %0d en %0d expected 0 0", rdn_lo - r0, en_cnt - e0); else n_pass++;
    n_chk++; if (u_oe !== 1'b0 || wrn !== 1'b1) $display("FAIL uwr_idle: got oe %b wrn %b expected 0 1", u_oe, wrn); else n_pass++;
  endtask

  task automatic test_uart_status();
    logic [DW-1:0] d; int lat, e0;
    logic [2:0] pat [3] = '{3'b111, 3'b110, 3'b011};
    for (int k = 0; k < 3; k++) begin
      {dready, tsre, tbre} = pat[k];
      repeat (3) sync_cyc();
      do_mem(1'b0, 18'h0BF01, 16'h0, d, lat);
      n_chk++; if (d !== {14'b0, pat[k][2], pat[k][1] & pat[k][0]} || lat != 2)
        $display("FAIL ustat[%0d]: got %h lat %0d expected %h lat 2", k, d, lat, {14'b0, pat[k][2], pat[k][1] & pat[k][0]}); else n_pass++;
      sync_cyc();
    end
    e0 = en_cnt;
    do_mem(1'b1, 18'h0BF01, 16'hFFFF, d, lat);
    sync_cyc();
    n_chk++; if (lat != 2 || en_cnt != e0) $display("FAIL ustat_wr: got lat %0d en %0d expected 2 0", lat, en_cnt - e0); else n_pass++;
  endtask

  task automatic test_uart_read();
    logic [DW-1:0] d, bus; int lat, r0, w0;
    for (int k = 0; k < 3; k++) begin
      bus = (k == 0) ? 16'hA55A : 16'($urandom);
      u_din = bus; r0 = rdn_lo; w0 = wrn_lo;
      do_mem(1'b0, 18'h0BF00, 16'h0, d, lat);
      sync_cyc();
      n_chk++; if (d !== {8'h00, bus[7:0]} || lat != UP + 1)
        $display("FAIL urd[%0d]: got %h lat %0d expected %h lat %0d", k, d, lat, {8'h00, bus[7:0]}, UP + 1); else n_pass++;
      n_chk++; if (rdn_lo - r0 != UP || wrn_lo != w0)
        $display("FAIL urd_strobe[%0d]: got rdn %0d wrn %0d expected %0d 0", k, rdn_lo - r0, wrn_lo - w0, UP); else n_pass++;
    end
  endtask
`else
  task automatic test_no_uart();
    logic [DW-1:0] d; int lat, e0, w0, o0;
    e0 = en_cnt; w0 = wrn_lo + rdn_lo; o0 = oe_cnt;
    do_mem(1'b1, 18'h0BF00, 16'h0041, d, lat);
    ref_mem[10'h300] = 16'h0041;
    sync_cyc();
    n_chk++; if (lat != SC + 1 || en_cnt - e0 != SC || en_addr !== 18'h0BF00)
      $display("FAIL nouart_wr: got lat %0d en %0d addr %h expected %0d %0d 0bf00", lat, en_cnt - e0, en_addr, SC + 1, SC); else n_pass++;
    n_chk++; if (wrn_lo + rdn_lo != w0 || oe_cnt != o0)
      $display("FAIL nouart_strobe: got %0d/%0d expected 0/0", wrn_lo + rdn_lo - w0, oe_cnt - o0); else n_pass++;
    do_mem(1'b0, 18'h0BF01, 16'h0, d, lat);
    sync_cyc();
    n_chk++; if (d !== ref_mem[10'h301] || lat != SC + 1)
      $display("FAIL nouart_rd: got %h lat %0d expected %h lat %0d", d, lat, ref_mem[10'h301], SC + 1); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    logic found; int a0, s0;
`ifdef MEM_ARB_UART_EN
    mem_addr = 18'h0BF00;
`else
    mem_addr = 18'h00050;
`endif
    mem_we = 1'b1; mem_wdata = 16'h0041; mem_req = 1'b1; found = 1'b0; a0 = ack_cnt;
    for (int i = 0; i < 20 && !found; i++) begin
      sync_cyc();
`ifdef MEM_ARB_UART_EN
      found = (wrn === 1'b0);
`else
      found = (ram_en === 1'b1);
`endif
    end
    n_chk++; if (!found) $display("FAIL rstmid_reach: got no access expected one within 20 cycles"); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if ({wrn, rdn, ram_en, mem_ack, u_oe} !== 5'b11000)
      $display("FAIL rstmid_out: got %b expected 11000", {wrn, rdn, ram_en, mem_ack, u_oe}); else n_pass++;
    mem_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; s0 = wrn_lo + rdn_lo;
    repeat (4) sync_cyc();
    n_chk++; if (ack_cnt != a0 || wrn_lo + rdn_lo != s0)
      $display("FAIL rstmid_after: got acks %0d strobes %0d expected 0 0", ack_cnt - a0, wrn_lo + rdn_lo - s0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = 16'(i * 40503 + 16'h1357);
      ref_mem[i] = 16'(i * 40503 + 16'h1357);
    end
    test_reset();
    test_if_read();
    test_simul();
    test_fair();
    test_random();
    test_if_uart_addr();
`ifdef MEM_ARB_UART_EN
    test_uart_write();
    test_uart_status();
    test_uart_read();
`else
    test_no_uart();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
